// File: rtl/cov_tst_stim.sv
// rtl/cov_tst_stim.sv - closed-loop coverage stimulus sequencer
// Steers LFSR stimulus toward uncovered DUT next-state branches until each is hit HITS times.
module cov_tst_stim #(
  parameter int         HITS       = 4,
  parameter logic [7:0] SEED       = 8'hA5,
  parameter int         MAX_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dut_out,
  output logic [7:0] dut_in,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [3:0] hit_mask,
  output logic [9:0] cycle_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  logic [1:0] state;
  logic [1:0] ptr;
  logic [7:0] lfsr;
  logic [3:0] cnt [4];

  logic [1:0] bin;
  logic [1:0] ptr_nxt;
  logic [1:0] idx;
  logic       found;
  logic [7:0] lfsr_nxt;
  logic [7:0] shaped;
  logic [3:0] cnt_nxt [4];
  logic [3:0] mask_nxt;
  logic [9:0] cycle_nxt;

  always_comb begin
    bin      = 2'd0;
    ptr_nxt  = ptr;
    idx      = 2'd0;
    found    = 1'b0;
    shaped   = 8'd0;
    mask_nxt = 4'd0;
    // The vector on dut_in now is what the DUT consumes at the coming edge.
    if (dut_in[7])
      bin = (dut_out > 8'd100) ? 2'd0 : 2'd1;
    else
      bin = (dut_in < 8'd70) ? 2'd2 : 2'd3;
    for (int i = 0; i < 4; i++) begin
      cnt_nxt[i] = cnt[i];
      if (bin == 2'(i) && cnt[i] != 4'(HITS))
        cnt_nxt[i] = cnt[i] + 4'd1;
      mask_nxt[i] = (cnt_nxt[i] == 4'(HITS));
    end
    lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    // Round-robin: first uncovered bin strictly after the current target.
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && !mask_nxt[idx]) begin
        ptr_nxt = idx;
        found   = 1'b1;
      end
    end
    case (ptr_nxt)
      2'd2:    shaped = {2'b00, lfsr_nxt[5:0]};
      2'd3:    shaped = {3'b011, lfsr_nxt[4:0]};
      default: shaped = {1'b1, lfsr_nxt[6:0]};
    endcase
    cycle_nxt = cycle_cnt + 10'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= 2'd0;
      lfsr      <= SEED;
      dut_in    <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      hit_mask  <= 4'd0;
      cycle_cnt <= 10'd0;
      for (int i = 0; i < 4; i++) cnt[i] <= 4'd0;
    end else begin
      case (state)
        S_RUN: begin
          for (int i = 0; i < 4; i++) cnt[i] <= cnt_nxt[i];
          hit_mask  <= mask_nxt;
          lfsr      <= lfsr_nxt;
          ptr       <= ptr_nxt;
          cycle_cnt <= cycle_nxt;
          if (&mask_nxt) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            dut_in <= 8'd0;
          end else if (cycle_nxt == 10'(MAX_CYCLES)) begin
            state  <= S_FAIL;
            busy   <= 1'b0;
            fail   <= 1'b1;
            dut_in <= 8'd0;
          end else begin
            dut_in <= shaped;
          end
        end
        default: begin
          if (start) begin
            state     <= S_RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
            hit_mask  <= 4'd0;
            cycle_cnt <= 10'd0;
            ptr       <= 2'd0;
            lfsr      <= SEED;
            dut_in    <= {1'b1, SEED[6:0]};
            for (int i = 0; i < 4; i++) cnt[i] <= 4'd0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cov_tst_stim.sv
// tb/tb_cov_tst_stim.sv - testbench for cov_tst_stim
// Three instances: budget-limited (A), HITS=2 (B), closed loop with a coverage DUT model (C).
module tb_cov_tst_stim;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [7:0] out_a = 8'd0, out_b = 8'd50, cov_out;
  logic [7:0] in_a, in_b, in_c;
  logic busy_a, done_a, fail_a, busy_b, done_b, fail_b, busy_c, done_c, fail_c;
  logic [3:0] mask_a, mask_b, mask_c;
  logic [9:0] cyc_a, cyc_b, cyc_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cov_tst_stim #(.HITS(4), .SEED(8'hA5), .MAX_CYCLES(50)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_out(out_a), .dut_in(in_a),
    .busy(busy_a), .done(done_a), .fail(fail_a), .hit_mask(mask_a), .cycle_cnt(cyc_a));
  cov_tst_stim #(.HITS(2), .SEED(8'hA5), .MAX_CYCLES(1000)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_out(out_b), .dut_in(in_b),
    .busy(busy_b), .done(done_b), .fail(fail_b), .hit_mask(mask_b), .cycle_cnt(cyc_b));
  cov_tst_stim #(.HITS(4), .SEED(8'hA5), .MAX_CYCLES(1000)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .dut_out(cov_out), .dut_in(in_c),
    .busy(busy_c), .done(done_c), .fail(fail_c), .hit_mask(mask_c), .cycle_cnt(cyc_c));

  // Coverage DUT stand-in; restarts from 0 whenever a run is armed.
  always @(posedge clk or posedge rst) begin
    if (rst) cov_out <= 8'd0;
    else if (start_c && !busy_c) cov_out <= 8'd0;
    else if (in_c[7]) cov_out <= (cov_out > 8'd100) ? (cov_out >> 1) : cov_out + {1'b0, in_c[6:0]};
    else cov_out <= in_c;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int bin_of(input logic [7:0] din, input logic [7:0] dout);
    if (din[7]) return (dout > 8'd100) ? 0 : 1;
    return (din < 8'd70) ? 2 : 3;
  endfunction

  // Reference model for instance A (HITS=4, MAX_CYCLES=50)
  int         m_state;   // 0 idle, 1 run, 2 done, 3 fail
  int         m_cnt [4];
  int         m_ptr, m_cyc;
  logic [7:0] m_lfsr, m_in;

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_cyc = 0; m_lfsr = 8'hA5; m_in = 8'd0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic model_step(input logic st, input logic [7:0] dout);
    int b, c;
    bit all;
    if (m_state == 1) begin
      b = bin_of(m_in, dout);
      if (m_cnt[b] < 4) m_cnt[b]++;
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
      m_cyc++;
      all = 1'b1;
      for (int i = 0; i < 4; i++) if (m_cnt[i] < 4) all = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        c = (m_ptr + k) % 4;
        if (m_cnt[c] < 4) begin m_ptr = c; break; end
      end
      if (all) begin m_state = 2; m_in = 8'd0; end
      else if (m_cyc == 50) begin m_state = 3; m_in = 8'd0; end
      else if (m_ptr < 2) m_in = 8'(128 + m_lfsr % 128);
      else if (m_ptr == 2) m_in = 8'(m_lfsr % 64);
      else m_in = 8'(96 + m_lfsr % 32);
    end else if (st) begin
      m_state = 1; m_ptr = 0; m_cyc = 0; m_lfsr = 8'hA5; m_in = 8'hA5;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end
  endtask

  function automatic logic [24:0] model_vec();
    logic [3:0] mk;
    for (int i = 0; i < 4; i++) mk[i] = (m_cnt[i] == 4);
    return {m_in, m_state == 1, m_state == 2, m_state == 3, mk, 10'(m_cyc)};
  endfunction

  typedef struct {
    logic [7:0] dout;
    logic [3:0] mask;
    logic       fl;
    int         cycles;
  } vec_t;
  vec_t tbl [5];

  logic [7:0] cur [$];
  logic [7:0] seq0 [$];
  int         bc [4];

  task automatic run_c(input bit poke);
    int n;
    cur.delete();
    for (int i = 0; i < 4; i++) bc[i] = 0;
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    n = 0;
    while (busy_c && n < 1100) begin
      cur.push_back(in_c);
      bc[bin_of(in_c, cov_out)]++;
      start_c = (poke && n == 5);
      @(negedge clk);
      n++;
    end
    start_c = 1'b0;
    check("c_finished", !busy_c, 1);
    check("c_done", {done_c, fail_c}, 2'b10);
    check("c_mask", mask_c, 4'hF);
    check("c_cyc_range", (cyc_c >= 16 && cyc_c < 1000), 1);
    check("c_cyc_len", cyc_c, cur.size());
    check("c_in_zero", in_c, 8'd0);
    for (int i = 0; i < 4; i++) check($sformatf("c_bin%0d", i), (bc[i] > 4) ? 4 : bc[i], 4);
  endtask

  initial begin
    int n, bad;
    logic st;
    logic [7:0] d;

    tbl[0] = '{8'd200, 4'b1101, 1'b1, 50};
    tbl[1] = '{8'd101, 4'b1101, 1'b1, 50};
    tbl[2] = '{8'd100, 4'b1110, 1'b1, 50};
    tbl[3] = '{8'd50,  4'b1110, 1'b1, 50};
    tbl[4] = '{8'd0,   4'b1110, 1'b1, 50};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_state", {in_a, busy_a, done_a, fail_a, mask_a, cyc_a}, 25'd0);
    repeat (5) @(negedge clk);
    check("idle_hold", {in_a, busy_a}, 9'd0);

    // Asynchronous abort three cycles into a run
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("start_busy", {busy_a, in_a}, {1'b1, 8'hA5});
    @(negedge clk);
    @(negedge clk);
    check("run_cyc", cyc_a, 10'd2);
    #2 rst = 1'b1;
    #1 check("async_rst", {busy_a, in_a, mask_a, cyc_a}, 23'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fixed dut_out: one of bin0/bin1 unreachable, budget of 50 expires
    for (int i = 0; i < 5; i++) begin
      out_a = tbl[i].dout;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      n = 0;
      while (busy_a && n < 60) begin @(negedge clk); n++; end
      check($sformatf("tbl%0d_len", i), n, tbl[i].cycles);
      check($sformatf("tbl%0d_flags", i), {done_a, fail_a}, {1'b0, tbl[i].fl});
      check($sformatf("tbl%0d_mask", i), mask_a, tbl[i].mask);
      check($sformatf("tbl%0d_cyc", i), cyc_a, 10'(tbl[i].cycles));
      check($sformatf("tbl%0d_in", i), in_a, 8'd0);
    end

    // Randomized stimulus against the model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 800; k++) begin
      check("model", {in_a, busy_a, done_a, fail_a, mask_a, cyc_a}, model_vec());
      st = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       d = 8'd100;
        1:       d = 8'd101;
        default: d = 8'($urandom_range(0, 255));
      endcase
      start_a = st;
      out_a = d;
      model_step(st, d);
      @(negedge clk);
    end
    start_a = 1'b0;

    // HITS=2, dut_out=50: bin0 unreachable; shaping ranges checked
    bad = 0;
    for (int i = 0; i < 4; i++) bc[i] = 0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (busy_b && n < 1100) begin
      if (!in_b[7] && !(in_b <= 8'd63 || (in_b >= 8'd96 && in_b <= 8'd127))) bad++;
      bc[bin_of(in_b, out_b)]++;
      @(negedge clk);
      n++;
    end
    check("b_len", n, 1000);
    check("b_flags", {done_b, fail_b}, 2'b01);
    check("b_mask", mask_b, 4'b1110);
    check("b_cyc", cyc_b, 10'd1000);
    check("b_in", in_b, 8'd0);
    check("b_shape_bad", bad, 0);
    check("b_bin0", bc[0], 0);
    for (int i = 1; i < 4; i++) check($sformatf("b_bin%0d", i), (bc[i] > 2) ? 2 : bc[i], 2);

    // Closed loop: mid-run start ignored, rerun after DONE identical
    run_c(1'b1);
    seq0 = cur;
    @(negedge clk);
    run_c(1'b0);
    check("c_first", (cur.size() > 0) ? cur[0] : 8'h00, 8'hA5);
    check("c_len_eq", cur.size(), seq0.size());
    bad = 0;
    for (int i = 0; i < cur.size() && i < seq0.size(); i++) if (cur[i] !== seq0[i]) bad++;
    check("c_seq_eq", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
